sprite_pos_regs: RTL and testbench

- CPU-side register bank that holds the five sprite positions driven into the VGA top level (posx1..posy5).
- The ARMv4 core writes positions over its data-memory bus into shadow registers and requests a commit.
- Shadow values are copied to the active outputs only at the start of a VGA vsync pulse, so frames never tear.
- Also provides a frame counter and a one-cycle frame tick that the game loop uses for pacing.

---
 rtl/sprite_regs_pkg.sv | 17 +
 rtl/vsync_edge_sync.sv | 31 +++
 rtl/sprite_pos_regs.sv | 131 +++++++++++++
 tb/tb_sprite_pos_regs.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_regs_pkg.sv
// Shared definitions for the sprite position register bank: word map,
// CTRL bit layout and the commit state encoding.
package sprite_regs_pkg;

  localparam int unsigned CTRL_W        = 8;
  localparam int unsigned FRAME_W       = 9;
  localparam int unsigned CTRL_PEND_BIT = 0;
  localparam int unsigned CTRL_VS_BIT   = 1;

  typedef logic [10:0] pos_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_t;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the active-low VGA vsync into the clk domain and flags its falling
// edge (start of the sync pulse) for exactly one clk cycle.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic vs_level,
  output logic vs_fall
);

  logic vs_s1;
  logic vs_s2;
  logic vs_d;

  // Flops reset high so an idle (high) vsync never produces a spurious fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_d  <= 1'b1;
    end else begin
      vs_s1 <= vsync_in;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  assign vs_level = vs_s2;
  assign vs_fall  = vs_d & ~vs_s2;

endmodule

// File: rtl/sprite_pos_regs.sv
// CPU-visible sprite position bank: shadow registers written over the data bus,
// copied to the active outputs at vsync start when a commit is pending.
module sprite_pos_regs
  import sprite_regs_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0400,
  parameter int unsigned POS_W       = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  input  logic                         vsync_in,
  output logic [NUM_SPRITES*POS_W-1:0] pos_x,
  output logic [NUM_SPRITES*POS_W-1:0] pos_y,
  output logic                         frame_tick
);

  logic             sel;
  logic [5:0]       word;
  logic             ctrl_set;
  logic             commit;
  logic             vs_level;
  logic             vs_fall;
  logic [15:0]      frame_cnt;
  logic [31:0]      rd_next;
  logic             unused_bits;
  commit_state_t    state, state_next;

  logic [POS_W-1:0] shadow_x [NUM_SPRITES];
  logic [POS_W-1:0] shadow_y [NUM_SPRITES];
  logic [POS_W-1:0] act_x    [NUM_SPRITES];
  logic [POS_W-1:0] act_y    [NUM_SPRITES];

  assign sel         = (addr[31:8] == ADDR_BASE[31:8]);
  assign word        = addr[7:2];
  assign ctrl_set    = we & sel & (word == 6'(CTRL_W)) & wdata[CTRL_PEND_BIT];
  assign commit      = (state == PEND) & vs_fall;
  assign unused_bits = ^{addr[1:0], wdata};

  vsync_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .vs_level (vs_level),
    .vs_fall  (vs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A set landing on the commit edge wins, so the new request survives it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (ctrl_set) state_next = PEND;
      PEND: if (vs_fall)  state_next = ctrl_set ? PEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Commit samples shadow before this cycle's bus write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        act_x[i]    <= '0;
        act_y[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (commit) begin
          act_x[i] <= shadow_x[i];
          act_y[i] <= shadow_y[i];
        end
        if (we && sel && (word == 6'(i))) begin
          shadow_x[i] <= wdata[POS_W-1:0];
          shadow_y[i] <= wdata[16 +: POS_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= vs_fall;
      if (vs_fall) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_next = '0;
    if (sel) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (word == 6'(i)) begin
          rd_next[POS_W-1:0]  = shadow_x[i];
          rd_next[16 +: POS_W] = shadow_y[i];
        end
      end
      if (word == 6'(CTRL_W)) begin
        rd_next[CTRL_PEND_BIT] = (state == PEND);
        rd_next[CTRL_VS_BIT]   = vs_level;
      end
      if (word == 6'(FRAME_W)) rd_next[15:0] = frame_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= rd_next;
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      pos_x[POS_W*i +: POS_W] = act_x[i];
      pos_y[POS_W*i +: POS_W] = act_y[i];
    end
  end

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Directed bench for sprite_pos_regs with a reference model and a read scoreboard.
module tb_sprite_pos_regs;

  localparam int NS = 5;
  localparam int PW = 11;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] CTRL  = BASE + 32'h20;
  localparam logic [31:0] FRAME = BASE + 32'h24;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              vsync_in;
  logic [NS*PW-1:0]  pos_x;
  logic [NS*PW-1:0]  pos_y;
  logic              frame_tick;

  int vectors     = 0;
  int miscompares = 0;
  int ticks       = 0;
  int pulses      = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [PW-1:0] sx[NS], sy[NS], ax[NS], ay[NS];
  logic          pend;
  logic [15:0]   fc;

  always #5 clk = ~clk;

  sprite_pos_regs #(
    .NUM_SPRITES (NS),
    .ADDR_BASE   (BASE),
    .POS_W       (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .vsync_in   (vsync_in),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .frame_tick (frame_tick)
  );

  always @(negedge clk) if (frame_tick === 1'b1) ticks++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sx[i] = '0; sy[i] = '0; ax[i] = '0; ay[i] = '0;
    end
    pend = 1'b0;
    fc   = '0;
  endtask

  task automatic model_fall();
    if (pend) begin
      for (int i = 0; i < NS; i++) begin
        ax[i] = sx[i];
        ay[i] = sy[i];
      end
      pend = 1'b0;
    end
    fc = fc + 16'd1;
    pulses++;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = 32'(a[7:2]);
    if (a[31:8] == BASE[31:8]) begin
      if (w < NS) begin
        sx[w] = d[PW-1:0];
        sy[w] = d[16 +: PW];
      end
      if (w == 8 && d[0]) pend = 1'b1;
    end
  endtask

  function automatic logic [31:0] sprite_word(input int i);
    logic [31:0] r;
    r = '0;
    r[PW-1:0]  = sx[i];
    r[16 +: PW] = sy[i];
    return r;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    model_write(a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    logic [31:0] obs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    addr = a; we = 1'b0;
    @(negedge clk);
    obs = rdata;
    chk(tag_q.pop_front(), 64'(obs), 64'(exp_q.pop_front()));
  endtask

  task automatic chk_pos(input string tag);
    logic [NS*PW-1:0] ex, ey;
    for (int i = 0; i < NS; i++) begin
      ex[PW*i +: PW] = ax[i];
      ey[PW*i +: PW] = ay[i];
    end
    chk({tag, "_x"}, 64'(pos_x), 64'(ex));
    chk({tag, "_y"}, 64'(pos_y), 64'(ey));
  endtask

  task automatic pulse();
    @(negedge clk) vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    model_fall();
  endtask

  // Bus write lands on the same edge that sees vs_fall.
  task automatic pulse_with_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    model_fall();
    model_write(a, d);
  endtask

  initial begin
    int  n;
    bit  found;
    int  t0;

    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; vsync_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk_pos("reset_pos");
    rst = 1'b0;

    for (int i = 0; i < NS; i++) rd(BASE + 32'(4 * i), 32'h0, $sformatf("reset_sprite%0d", i));
    rd(CTRL,  32'h2, "reset_ctrl");
    rd(FRAME, 32'h0, "reset_frame");
    chk("reset_no_tick", 64'(ticks), 64'd0);

    wr(BASE + 32'h8, 32'h0064_00C8);
    rd(BASE + 32'h8, 32'h0064_00C8, "sprite2_readback");
    repeat (3) pulse();
    chk_pos("no_commit_pos");
    rd(FRAME, 32'(fc), "frame_after3");
    chk("frame_val3", 64'(fc), 64'd3);
    chk("ticks3", 64'(ticks), 64'd3);

    wr(BASE + 32'h44, 32'hFFFF_FFFF);
    rd(BASE + 32'h28, 32'h0, "unused_word_read");
    rd(BASE + 32'h100, 32'h0, "unselected_read");

    wr(BASE, 32'h0020_0010);
    wr(CTRL, 32'h1);
    rd(CTRL, 32'h3, "ctrl_pending");
    t0 = ticks;
    @(negedge clk) vsync_in = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 6 && !found; i++) begin
      @(negedge clk);
      if (pos_x[PW-1:0] == 11'd16) begin
        found = 1'b1;
        n = i;
      end
    end
    chk("commit_latency_ok", 64'(found && n >= 2 && n <= 3), 64'd1);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    model_fall();
    chk_pos("commit_pos");
    chk("commit_y0", 64'(pos_y[PW-1:0]), 64'd32);
    rd(CTRL, 32'h2, "ctrl_cleared");
    chk("one_tick", 64'(ticks - t0), 64'd1);

    wr(BASE + 32'h4, 32'h5);
    wr(CTRL, 32'h1);
    pulse_with_write(BASE + 32'h4, 32'h7);
    chk_pos("simul_write_pos");
    chk("simul_active_x1", 64'(pos_x[PW +: PW]), 64'd5);
    rd(BASE + 32'h4, sprite_word(1), "simul_shadow1");
    rd(CTRL, 32'h2, "simul_ctrl_idle");

    wr(CTRL, 32'h1);
    pulse_with_write(CTRL, 32'h1);
    chk_pos("set_at_fall_pos");
    chk("set_at_fall_x1", 64'(pos_x[PW +: PW]), 64'd7);
    rd(CTRL, 32'h3, "set_at_fall_ctrl");
    pulse();
    chk_pos("pend_kept_pos");
    rd(CTRL, 32'h2, "pend_kept_ctrl");

    pulse_with_write(CTRL, 32'h1);
    rd(CTRL, 32'h3, "idle_set_at_fall_ctrl");
    chk_pos("idle_set_at_fall_pos");
    pulse();

    @(negedge clk) force dut.frame_cnt = 16'hFFFE;
    @(negedge clk) release dut.frame_cnt;
    fc = 16'hFFFE;
    pulse();
    rd(FRAME, 32'h0000_FFFF, "frame_ffff");
    pulse();
    rd(FRAME, 32'h0000_0000, "frame_wrap");

    wr(BASE + 32'hC, 32'h0123_0456);
    wr(CTRL, 32'h1);
    @(negedge clk) rst = 1'b1;
    #1;
    model_reset();
    chk_pos("async_reset_pos");
    chk("async_reset_rdata", 64'(rdata), 64'd0);
    chk("async_reset_tick", 64'(frame_tick), 64'd0);
    @(negedge clk) rst = 1'b0;
    pulse();
    chk_pos("post_reset_pos");
    rd(CTRL, 32'h2, "post_reset_ctrl");
    rd(BASE + 32'hC, 32'h0, "post_reset_shadow3");
    rd(FRAME, 32'h1, "post_reset_frame");
    chk("total_ticks", 64'(ticks), 64'(pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
